// File: rtl/shift_reg_pkg.sv
// Shared types for the command-driven universal shift register: opcodes and FSM states.
package shift_reg_pkg;

  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_SHL  = 3'd1,
    OP_SHR  = 3'd2,
    OP_ASR  = 3'd3,
    OP_ROL  = 3'd4,
    OP_ROR  = 3'd5
  } op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/shift_step_unit.sv
// Combinational single-step shifter: applies one shift/rotate of s bits (0..STEP) to value.
module shift_step_unit
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  parameter int SW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] value,
  input  op_e              op,
  input  logic [SW-1:0]    s,
  input  logic             sin,
  output logic [WIDTH-1:0] next_value,
  output logic             out_bit
);

  logic [WIDTH-1:0] ones;
  logic [WIDTH-1:0] lo_sh;
  logic [WIDTH-1:0] hi_sh;

  // lo_sh[0] is the last bit leaving the LSB side, hi_sh[0] the last leaving the MSB side
  assign ones  = {WIDTH{1'b1}};
  assign lo_sh = value >> (int'(s) - 1);
  assign hi_sh = value >> (WIDTH - int'(s));

  always_comb begin
    next_value = value;
    out_bit    = 1'b0;
    case (op)
      OP_SHL: begin
        next_value = (value << s) | (sin ? ~(ones << s) : '0);
        out_bit    = hi_sh[0];
      end
      OP_SHR: begin
        next_value = (value >> s) | (sin ? ~(ones >> s) : '0);
        out_bit    = lo_sh[0];
      end
      OP_ASR: begin
        next_value = $signed(value) >>> s;
        out_bit    = lo_sh[0];
      end
      OP_ROL: begin
        next_value = (value << s) | (value >> (WIDTH - int'(s)));
        out_bit    = hi_sh[0];
      end
      OP_ROR: begin
        next_value = (value >> s) | (value << (WIDTH - int'(s)));
        out_bit    = lo_sh[0];
      end
      default: begin
        next_value = value;
        out_bit    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_reg_seq.sv
// Command-driven universal shift register: accepts LOAD/shift/rotate commands over valid/ready
// and executes shifts at up to STEP bits per enabled cycle, then pulses done for one cycle.
module shift_reg_seq
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  parameter int AMT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             sin,
  output logic [WIDTH-1:0] data_out,
  output logic             sout,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int SW = $clog2(STEP + 1);

  logic [1:0]       state_q, state_d;
  op_e              op_q, op_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sout_q, sout_d;
  logic             err_q, err_d;

  logic [AMT_W-1:0] amt_clamp;
  logic [AMT_W-1:0] amt_mod;
  logic [SW-1:0]    s;
  logic [WIDTH-1:0] step_value;
  logic             step_out;

  // cmd_amt never exceeds 2*WIDTH-1, so one conditional subtract yields amt mod WIDTH
  assign amt_clamp = (cmd_amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : cmd_amt;
  assign amt_mod   = (cmd_amt >= AMT_W'(WIDTH)) ? cmd_amt - AMT_W'(WIDTH) : cmd_amt;
  assign s         = (rem_q < AMT_W'(STEP)) ? SW'(rem_q) : SW'(STEP);

  shift_step_unit #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .value      (data_q),
    .op         (op_q),
    .s          (s),
    .sin        (sin),
    .next_value (step_value),
    .out_bit    (step_out)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    data_d  = data_q;
    sout_d  = sout_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d  = op_e'(cmd_op);
          err_d = 1'b0;
          case (cmd_op)
            OP_LOAD: begin
              data_d  = cmd_data;
              state_d = ST_DONE;
            end
            OP_SHL, OP_SHR, OP_ASR: begin
              rem_d   = amt_clamp;
              state_d = (amt_clamp == '0) ? ST_DONE : ST_RUN;
            end
            OP_ROL, OP_ROR: begin
              rem_d   = amt_mod;
              state_d = (amt_mod == '0) ? ST_DONE : ST_RUN;
            end
            default: begin
              err_d   = 1'b1;
              state_d = ST_DONE;
            end
          endcase
        end
      end
      ST_RUN: begin
        if (enable) begin
          data_d = step_value;
          sout_d = step_out;
          rem_d  = rem_q - AMT_W'(s);
          if (rem_d == '0) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      rem_q   <= '0;
      data_q  <= '0;
      sout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      sout_q  <= sout_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = done & err_q;
  assign data_out  = data_q;
  assign sout      = sout_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Directed bench for shift_reg_seq: a STEP=1 instance and a STEP=4 instance share all inputs.
module tb_shift_reg_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_amt;
  logic [15:0] cmd_data;
  logic        sin;

  logic        ready1, busy1, done1, err1, sout1;
  logic [15:0] data1;
  logic        ready4, busy4, done4, err4, sout4;
  logic [15:0] data4;

  int cyc = 0;
  int a_cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int lat;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_reg_seq #(.WIDTH(16), .STEP(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .cmd_valid(cmd_valid), .cmd_ready(ready1),
    .cmd_op(cmd_op), .cmd_amt(cmd_amt), .cmd_data(cmd_data), .sin(sin),
    .data_out(data1), .sout(sout1), .busy(busy1), .done(done1), .err(err1)
  );

  shift_reg_seq #(.WIDTH(16), .STEP(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .cmd_valid(cmd_valid), .cmd_ready(ready4),
    .cmd_op(cmd_op), .cmd_amt(cmd_amt), .cmd_data(cmd_data), .sin(sin),
    .data_out(data4), .sout(sout4), .busy(busy4), .done(done4), .err(err4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one command; returns 1 time unit after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [4:0] amt,
                      input logic [15:0] d, input logic s_in);
    @(negedge clk);
    cmd_op    = op;
    cmd_amt   = amt;
    cmd_data  = d;
    sin       = s_in;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    a_cyc     = cyc;
  endtask

  // Poll done of the chosen instance; latency counted so that done right after accept is 1.
  task automatic wait_done(input int sel, output int l);
    int k = 0;
    while (!(sel == 4 ? done4 : done1) && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 200) chk("done_timeout", 0, 1);
    l = cyc - a_cyc + 1;
  endtask

  task automatic to_idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_amt   = 5'd0;
    cmd_data  = 16'h0000;
    sin       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", data1, 16'h0000);
    chk("rst_sout", sout1, 0);
    chk("rst_ready", ready1, 1);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_err", err1, 0);
    @(negedge clk);
    reset = 1'b0;

    send(3'd0, 5'd0, 16'h8001, 1'b0);
    wait_done(1, lat);
    chk("load_lat", lat, 1);
    chk("load_data", data1, 16'h8001);
    chk("load_ready_in_done", ready1, 0);
    chk("load_err", err1, 0);
    to_idle();
    chk("idle_ready", ready1, 1);

    send(3'd1, 5'd4, 16'h0000, 1'b1);
    chk("shl_busy", busy1, 1);
    wait_done(1, lat);
    chk("shl_lat", lat, 5);
    chk("shl_data", data1, 16'h001F);
    chk("shl_sout", sout1, 0);
    chk("shl4_data", data4, 16'h001F);
    to_idle();

    send(3'd0, 5'd0, 16'h8000, 1'b0);
    wait_done(1, lat);
    to_idle();
    send(3'd3, 5'd3, 16'h0000, 1'b0);
    wait_done(1, lat);
    chk("asr_lat", lat, 4);
    chk("asr_data", data1, 16'hF000);
    chk("asr_sout", sout1, 0);
    to_idle();

    send(3'd2, 5'd20, 16'h0000, 1'b0);
    wait_done(1, lat);
    chk("shr_clamp_lat", lat, 17);
    chk("shr_clamp_data", data1, 16'h0000);
    chk("shr_clamp_sout", sout1, 1);
    to_idle();

    send(3'd0, 5'd0, 16'h0001, 1'b0);
    wait_done(1, lat);
    to_idle();
    send(3'd5, 5'd17, 16'h0000, 1'b0);
    wait_done(1, lat);
    chk("ror_lat", lat, 2);
    chk("ror_data", data1, 16'h8000);
    chk("ror_sout", sout1, 1);
    to_idle();

    send(3'd2, 5'd0, 16'h0000, 1'b1);
    wait_done(1, lat);
    chk("amt0_lat", lat, 1);
    chk("amt0_data", data1, 16'h8000);
    chk("amt0_sout", sout1, 1);
    chk("amt0_err", err1, 0);
    to_idle();

    send(3'd0, 5'd0, 16'h1234, 1'b0);
    wait_done(1, lat);
    to_idle();
    send(3'd4, 5'd6, 16'h0000, 1'b0);
    wait_done(4, lat);
    chk("rol4_lat", lat, 3);
    chk("rol4_data", data4, 16'h8D04);
    chk("rol4_sout", sout4, 0);
    wait_done(1, lat);
    chk("rol1_lat", lat, 7);
    chk("rol1_data", data1, 16'h8D04);
    to_idle();

    send(3'd0, 5'd0, 16'h8001, 1'b0);
    wait_done(1, lat);
    to_idle();
    send(3'd1, 5'd4, 16'h0000, 1'b1);
    @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stall_busy", busy1, 1);
    chk("stall_data", data1, 16'h0003);
    enable = 1'b1;
    wait_done(1, lat);
    chk("stall_lat", lat, 8);
    chk("stall_data_end", data1, 16'h001F);
    to_idle();

    send(3'd7, 5'd3, 16'hFFFF, 1'b0);
    wait_done(1, lat);
    chk("ill_lat", lat, 1);
    chk("ill_err", err1, 1);
    chk("ill_data", data1, 16'h001F);
    to_idle();
    chk("ill_err_after", err1, 0);

    send(3'd0, 5'd0, 16'hE000, 1'b0);
    wait_done(1, lat);
    to_idle();
    send(3'd1, 5'd10, 16'h0000, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_data", data1, 16'h0000);
    chk("mid_rst_sout", sout1, 0);
    chk("mid_rst_busy", busy1, 0);
    chk("mid_rst_ready", ready1, 1);
    @(negedge clk);
    reset = 1'b0;
    send(3'd0, 5'd0, 16'h00A5, 1'b0);
    wait_done(1, lat);
    chk("post_rst_lat", lat, 1);
    chk("post_rst_data", data1, 16'h00A5);
    to_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
